// File: rtl/sbox_pkg.sv
// Shared definitions for the AES byte-substitution engine: mode encodings,
// FSM state type and the forward/inverse S-box tables.
package sbox_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Forward S-box (SubBytes), indexed by {row nibble, column nibble}.
  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Inverse S-box (InvSubBytes), same indexing.
  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_rom.sv
// Single-byte combinational S-box: forward or inverse table chosen by mode.
module sbox_rom
  import sbox_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       mode_i,
  output logic [7:0] byte_o
);

  // Table select and lookup; the byte is the {row, column} index directly.
  always_comb begin
    byte_o = (mode_i == MODE_INV) ? SBOX_INV[byte_i] : SBOX_FWD[byte_i];
  end

endmodule

// File: rtl/sbox_lookup_engine.sv
// Multi-lane AES byte-substitution engine. A captured word is substituted in
// place, LPC lanes per cycle starting at lane 0, then held until downstream
// accepts it.
module sbox_lookup_engine
  import sbox_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_mode,
  output logic               busy
);

  localparam int N  = (LPC > 0) ? (LANES / LPC) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (LANES < 1 || LPC < 1 || (LANES % LPC) != 0) begin : g_bad_cfg
    $error("sbox_lookup_engine: LANES must be >= 1 and divisible by LPC");
  end

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [8*LANES-1:0] buf_q, buf_d;
  logic               mode_q, mode_d;

  logic [7:0]         rom_in  [LPC];
  logic [7:0]         rom_out [LPC];

  // Gather the lanes addressed by the current lookup slot.
  always_comb begin
    for (int g = 0; g < LPC; g++) begin
      rom_in[g] = buf_q[(int'(count_q) * LPC + g) * 8 +: 8];
    end
  end

  for (genvar g = 0; g < LPC; g++) begin : g_rom
    sbox_rom u_rom (
      .byte_i (rom_in[g]),
      .mode_i (mode_q),
      .byte_o (rom_out[g])
    );
  end

  // Next-state, buffer update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    buf_d     = buf_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          buf_d   = in_data;
          mode_d  = in_mode;
          count_d = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        busy = 1'b1;
        for (int g = 0; g < LPC; g++) begin
          buf_d[(int'(count_q) * LPC + g) * 8 +: 8] = rom_out[g];
        end
        // The last slot leaves count at N-1 so it never wraps.
        if (count_q == CW'(N - 1)) begin
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, buffer and mode registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      buf_q   <= '0;
      mode_q  <= MODE_FWD;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      mode_q  <= mode_d;
    end
  end

  assign out_data = buf_q;
  assign out_mode = mode_q;

endmodule

// File: doc/sbox_lookup_engine.md
Name: sbox_lookup_engine

Overview:
Parametrised AES byte-substitution engine. Accepts a word of LANES bytes over a valid/ready handshake and substitutes every byte through the forward S-box (SubBytes) or inverse S-box (InvSubBytes). It processes LPC bytes per cycle through LPC shared ROM instances, then returns the result over a valid/ready handshake. It sits between the round-datapath controller and the cipher state register, and replaces the single-byte, forward-only S-box memory.

Parameters:
LANES, 4, number of bytes per word; must be >= 1.
LPC, 1, lookups per cycle (ROM instances); must divide LANES; LANES/LPC = N lookup cycles.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  upstream word valid.
in_ready  out  1  engine can accept; high only in IDLE and low while rst is high.
in_data  in  8*LANES  lane i = in_data[8i+7:8i].
in_mode  in  1  0 = forward S-box, 1 = inverse S-box.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts.
out_data  out  8*LANES  substituted word, same lane order.
out_mode  out  1  mode the result was computed with.
busy  out  1  high in LOOKUP or DONE.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset: state=IDLE, count=0, buffer=0, mode register=0. Hence out_valid=0, out_data=0, out_mode=0, busy=0. in_ready=1 from the first cycle after rst deasserts.
- Lookup function: byte b maps to TABLE[b[7:4]*16 + b[3:0]]. TABLE is the forward or inverse table selected by the latched mode.
- FSM states: IDLE, LOOKUP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: buffer<=in_data, mode<=in_mode, count<=0, go to LOOKUP.
- LOOKUP:
  - Each cycle, lanes count*LPC .. count*LPC+LPC-1 of the buffer are replaced in place by their lookups; count++.
  - After the cycle where count==N-1, go to DONE.
  - Lane 0 is processed first.
  - in_ready=0; in_valid is ignored, and upstream holds its data.
- DONE:
  - out_valid=1; out_data=buffer; out_mode=mode.
  - All three outputs stay stable until out_valid && out_ready. On that handshake go to IDLE; out_valid drops the next cycle.
- Latency: out_valid is high N cycles after the accepting edge (LANES=4, LPC=1 gives 4; LPC=LANES gives 1).
- Throughput: one word per N+2 cycles minimum. DONE does not accept a new word in the same cycle.
- Backpressure: out_ready low holds DONE indefinitely and in_ready stays 0.
- out_ready while out_valid=0: no effect.
- rst in any state, including mid-LOOKUP or DONE: abort, no output is produced, return to reset values on the next edge.
- Counter width: $clog2(N) bits, min 1. count never wraps past N-1.
- Elaboration: error if LPC does not divide LANES, or if LANES < 1.

Decomposition:
- Package sbox_pkg:
  - SBOX_FWD and SBOX_INV: 256 x 8-bit constant arrays per FIPS-197.
  - MODE_FWD=1'b0, MODE_INV=1'b1.
  - State enum {IDLE, LOOKUP, DONE}.
- Sub-module sbox_rom: combinational, inputs byte and mode, output byte. Instantiated LPC times by the engine.

Test Plan:
- Forward word: LANES=4, LPC=1, in_data=32'hff530100, in_mode=0, out_ready=1. Expect out_data=32'h16ed7c63 and out_mode=0, with out_valid exactly 4 cycles after the accept edge.
- Inverse round-trip: in_data=32'h16ed7c63, in_mode=1. Expect out_data=32'hff530100. Also expect the exhaustive check to pass: all 256 byte values forward then inverse return the original value.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data. Expect out_data stable, in_ready=0 and new data not taken; one cycle after out_ready=1, expect in_ready=1.
- Reset mid-operation: assert rst for 1 cycle in the 2nd LOOKUP cycle. Expect no out_valid pulse, all outputs 0, in_ready=1 after the reset edge, and the next word processed correctly.
- LPC=LANES=4 configuration: input 32'h00000053. Expect 32'h636363ed one cycle after the accept edge, and busy high for exactly 2 cycles with out_ready=1.
- Back-to-back: in_valid held high with 3 words, out_ready=1. Expect acceptances spaced exactly N+2=6 cycles apart, results in order, and no lost or duplicated words.
